d_cache_axi_bridge: RTL and testbench

//  Downstream neighbour of the write-through data cache. Converts its single-word

---
 rtl/d_cache_axi_bridge_pkg.sv | 18 +
 rtl/d_cache_axi_bridge.sv | 156 +++++++++++++++
 tb/tb_d_cache_axi_bridge.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/d_cache_axi_bridge_pkg.sv
// Shared definitions for the cache-to-AXI3 bridge: FSM encoding and fixed AXI field values.
package d_cache_axi_bridge_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD_AR  = 3'd1,
    S_RD_R   = 3'd2,
    S_WR_AWW = 3'd3,
    S_WR_B   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [1:0] BURST_INCR     = 2'b01;
  localparam logic [1:0] RESP_OKAY      = 2'b00;
  localparam logic [3:0] LEN_SINGLE     = 4'd0;
  localparam logic [3:0] AXI_ID_DEFAULT = 4'd1;

endpackage

// File: rtl/d_cache_axi_bridge.sv
// Turns the data cache's single-word memory port into single-beat AXI3 transactions,
// one outstanding at a time, with the request latched on acceptance.
module d_cache_axi_bridge
  import d_cache_axi_bridge_pkg::*;
#(
  parameter int         A_WIDTH = 32,
  parameter logic [3:0] AXI_ID  = AXI_ID_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [A_WIDTH-1:0] m_a,
  input  logic [31:0]        m_din,
  output logic [31:0]        m_dout,
  input  logic               m_strobe,
  input  logic               m_rw,
  input  logic [3:0]         m_wen,
  input  logic [1:0]         m_size,
  output logic               m_ready,
  output logic               m_err,
  output logic [3:0]         arid,
  output logic [A_WIDTH-1:0] araddr,
  output logic [3:0]         arlen,
  output logic [2:0]         arsize,
  output logic [1:0]         arburst,
  output logic [1:0]         arlock,
  output logic [3:0]         arcache,
  output logic [2:0]         arprot,
  output logic               arvalid,
  input  logic               arready,
  input  logic [31:0]        rdata,
  input  logic [1:0]         rresp,
  input  logic               rlast,
  input  logic               rvalid,
  output logic               rready,
  output logic [3:0]         awid,
  output logic [A_WIDTH-1:0] awaddr,
  output logic [3:0]         awlen,
  output logic [2:0]         awsize,
  output logic [1:0]         awburst,
  output logic [1:0]         awlock,
  output logic [3:0]         awcache,
  output logic [2:0]         awprot,
  output logic               awvalid,
  input  logic               awready,
  output logic [3:0]         wid,
  output logic [31:0]        wdata,
  output logic [3:0]         wstrb,
  output logic               wlast,
  output logic               wvalid,
  input  logic               wready,
  input  logic [1:0]         bresp,
  input  logic               bvalid,
  output logic               bready
);

  state_t               state, state_nxt;
  logic [A_WIDTH-1:0]   a_q;
  logic [31:0]          din_q;
  logic [3:0]           wen_q;
  logic [1:0]           size_q;
  logic                 aw_done, w_done, err_q;
  logic                 accept, aw_hs, w_hs;
  logic                 unused_rlast;

  // Single-beat reads: the last flag carries no information.
  assign unused_rlast = rlast;

  assign accept = (state == S_IDLE) && m_strobe;
  assign aw_hs  = awvalid && awready;
  assign w_hs   = wvalid && wready;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (m_strobe) state_nxt = m_rw ? S_WR_AWW : S_RD_AR;
      S_RD_AR:  if (arready) state_nxt = S_RD_R;
      S_RD_R:   if (rvalid) state_nxt = S_DONE;
      S_WR_AWW: if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = S_WR_B;
      S_WR_B:   if (bvalid) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    arvalid = (state == S_RD_AR);
    rready  = (state == S_RD_R);
    awvalid = (state == S_WR_AWW) && !aw_done;
    wvalid  = (state == S_WR_AWW) && !w_done;
    bready  = (state == S_WR_B);
    m_ready = (state == S_DONE);
    m_err   = (state == S_DONE) && err_q;
  end

  // Request latch: the cache is free to change its outputs once accepted.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q    <= m_a;
      din_q  <= m_din;
      wen_q  <= m_wen;
      size_q <= m_size;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else if (state == S_WR_AWW) begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end
      if ((state == S_RD_R) && rvalid)      err_q <= (rresp != RESP_OKAY);
      else if ((state == S_WR_B) && bvalid) err_q <= (bresp != RESP_OKAY);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                           m_dout <= '0;
    else if ((state == S_RD_R) && rvalid) m_dout <= rdata;
  end

  assign arid    = AXI_ID;
  assign araddr  = a_q;
  assign arlen   = LEN_SINGLE;
  assign arsize  = {1'b0, size_q};
  assign arburst = BURST_INCR;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;

  assign awid    = AXI_ID;
  assign awaddr  = a_q;
  assign awlen   = LEN_SINGLE;
  assign awsize  = {1'b0, size_q};
  assign awburst = BURST_INCR;
  assign awlock  = 2'b00;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;

  assign wid     = AXI_ID;
  assign wdata   = din_q;
  assign wstrb   = wen_q;
  assign wlast   = 1'b1;

endmodule

// File: tb/tb_d_cache_axi_bridge.sv
// Scoreboard bench for d_cache_axi_bridge: randomized cache requests against a behavioural AXI slave.
module tb_d_cache_axi_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] m_a, m_din, m_dout;
  logic        m_strobe, m_rw, m_ready, m_err;
  logic [3:0]  m_wen;
  logic [1:0]  m_size;
  logic [3:0]  arid, arlen, arcache, awid, awlen, awcache, wid, wstrb;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [2:0]  arsize, arprot, awsize, awprot;
  logic [1:0]  arburst, arlock, awburst, awlock, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  always #5 clk = ~clk;

  d_cache_axi_bridge #(.A_WIDTH(32), .AXI_ID(4'd1)) dut (
    .clk(clk), .rst(rst), .m_a(m_a), .m_din(m_din), .m_dout(m_dout),
    .m_strobe(m_strobe), .m_rw(m_rw), .m_wen(m_wen), .m_size(m_size),
    .m_ready(m_ready), .m_err(m_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed { logic [31:0] a; logic [2:0] size; } addr_t;
  typedef struct packed { logic [31:0] d; logic [3:0] strb; } wbeat_t;
  typedef struct packed { logic [31:0] d; logic err; } done_t;

  addr_t  exp_ar_q[$];
  addr_t  exp_aw_q[$];
  wbeat_t exp_w_q[$];
  done_t  exp_done_q[$];

  // Per-transaction slave behaviour, set by the driver before each request
  int          d_ar, d_r, d_aw, d_w, d_b;
  logic [31:0] cur_rdata;
  logic [1:0]  cur_rresp, cur_bresp;
  logic [31:0] last_rdata = 32'h0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: handshake with nothing expected at %0t", nm, $time);
  endtask

  // Behavioural AXI slave; handshakes are predicted at the negedge before the posedge they occur on
  logic rst_s = 1'b1;
  always @(posedge clk) rst_s <= rst;

  initial begin
    int  c_ar, c_aw, c_w, c_r, c_b;
    bit  r_pend, b_pend, aw_got, w_got;
    bit  ar_hs, r_hs, aw_hs, w_hs, b_hs;
    bit  arv_prev, awv_prev, wv_prev;
    addr_t  ea;
    wbeat_t ew;
    c_ar = 0; c_aw = 0; c_w = 0; c_r = 0; c_b = 0;
    r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
    ar_hs = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0;
    arv_prev = 0; awv_prev = 0; wv_prev = 0;
    arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
    rdata = 0; rresp = 0; rlast = 1'b1; bresp = 0;
    forever begin
      @(negedge clk);
      if (rst_s) begin
        c_ar = 0; c_aw = 0; c_w = 0; c_r = 0; c_b = 0;
        r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
        ar_hs = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0;
        arv_prev = 0; awv_prev = 0; wv_prev = 0;
        arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
        continue;
      end
      if (arv_prev && !ar_hs) chk("arvalid_held", arvalid, 1);
      if (awv_prev && !aw_hs) chk("awvalid_held", awvalid, 1);
      if (wv_prev && !w_hs)   chk("wvalid_held", wvalid, 1);
      if (aw_hs) chk("awvalid_drop", awvalid, 0);
      if (w_hs)  chk("wvalid_drop", wvalid, 0);

      if (ar_hs) begin r_pend = 1; c_r = 0; c_ar = 0; end
      if (r_hs)  begin r_pend = 0; rvalid = 0; end
      if (aw_hs) begin aw_got = 1; c_aw = 0; end
      if (w_hs)  begin w_got = 1; c_w = 0; end
      if (aw_got && w_got) begin aw_got = 0; w_got = 0; b_pend = 1; c_b = 0; end
      if (b_hs)  begin b_pend = 0; bvalid = 0; end

      arready = arvalid && (c_ar >= d_ar);
      if (arvalid && !arready) c_ar++;
      awready = awvalid && (c_aw >= d_aw);
      if (awvalid && !awready) c_aw++;
      wready = wvalid && (c_w >= d_w);
      if (wvalid && !wready) c_w++;

      if (r_pend && !rvalid) begin
        if (c_r >= d_r) begin rvalid = 1; rdata = cur_rdata; rresp = cur_rresp; end
        else c_r++;
      end
      if (b_pend && !bvalid) begin
        if (c_b >= d_b) begin bvalid = 1; bresp = cur_bresp; end
        else c_b++;
      end

      ar_hs = arvalid && arready;
      r_hs  = rvalid && rready;
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      b_hs  = bvalid && bready;

      if (ar_hs) begin
        if (exp_ar_q.size() == 0) unexpected("ar");
        else begin
          ea = exp_ar_q.pop_front();
          chk("araddr", araddr, ea.a);
          chk("arsize", arsize, ea.size);
        end
      end
      if (aw_hs) begin
        if (exp_aw_q.size() == 0) unexpected("aw");
        else begin
          ea = exp_aw_q.pop_front();
          chk("awaddr", awaddr, ea.a);
          chk("awsize", awsize, ea.size);
        end
      end
      if (w_hs) begin
        if (exp_w_q.size() == 0) unexpected("w");
        else begin
          ew = exp_w_q.pop_front();
          chk("wdata", wdata, ew.d);
          chk("wstrb", wstrb, ew.strb);
          chk("wlast", wlast, 1);
        end
      end
      arv_prev = arvalid;
      awv_prev = awvalid;
      wv_prev  = wvalid;
    end
  end

  // Completion monitor
  initial begin
    done_t e;
    forever begin
      @(negedge clk);
      if (m_ready === 1'b1) begin
        if (exp_done_q.size() == 0) unexpected("m_ready");
        else begin
          e = exp_done_q.pop_front();
          chk("m_dout", m_dout, e.d);
          chk("m_err", m_err, e.err);
        end
      end
    end
  end

  task automatic scramble();
    m_strobe = 1'b0;
    m_a      = $urandom;
    m_din    = $urandom;
    m_wen    = 4'($urandom);
    m_size   = 2'($urandom);
    m_rw     = 1'($urandom);
  endtask

  // One request; returns at the negedge on which m_ready is seen. b2b=1 issues in the DONE cycle.
  task automatic issue(input bit rw, input logic [31:0] a, input logic [1:0] size,
                       input logic [3:0] wen, input logic [31:0] din,
                       input int dar, input int dr, input int daw, input int dw, input int db,
                       input logic [1:0] resp, input logic [31:0] rd, input bit b2b);
    int cnt;
    int exp_lat;
    if (!b2b) repeat (1 + $urandom_range(0, 2)) @(negedge clk);
    d_ar = dar; d_r = dr; d_aw = daw; d_w = dw; d_b = db;
    cur_rdata = rd; cur_rresp = resp; cur_bresp = resp;
    if (!rw) begin
      exp_ar_q.push_back('{a: a, size: {1'b0, size}});
      last_rdata = rd;
      exp_lat = 3 + dar + dr;
    end else begin
      exp_aw_q.push_back('{a: a, size: {1'b0, size}});
      exp_w_q.push_back('{d: din, strb: wen});
      exp_lat = 3 + ((daw > dw) ? daw : dw) + db;
    end
    exp_done_q.push_back('{d: last_rdata, err: (resp != 2'b00)});
    m_rw = rw; m_a = a; m_size = size; m_wen = wen; m_din = din; m_strobe = 1'b1;
    repeat (b2b ? 2 : 1) @(negedge clk);
    scramble();
    cnt = 1;
    while (m_ready !== 1'b1 && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
    if (m_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL timeout: no m_ready after %0d cycles", cnt);
    end else begin
      chk("latency", cnt, exp_lat);
    end
  endtask

  initial begin
    d_ar = 0; d_r = 0; d_aw = 0; d_w = 0; d_b = 0;
    cur_rdata = 0; cur_rresp = 0; cur_bresp = 0;
    scramble();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_bready", bready, 0);
    chk("rst_m_ready", m_ready, 0);
    chk("rst_m_err", m_err, 0);
    chk("rst_m_dout", m_dout, 0);
    chk("tie_arid", arid, 4'd1);
    chk("tie_wid", wid, 4'd1);
    chk("tie_awburst", awburst, 2'b01);
    chk("tie_arlen", arlen, 4'd0);
    rst = 1'b0;

    // Zero-wait read
    issue(0, 32'h1000_0004, 2'd2, 4'hf, 32'h0, 0, 0, 0, 0, 0, 2'b00, 32'hDEAD_BEEF, 0);
    // Write with W accepted three cycles ahead of AW
    issue(1, 32'h2000_0010, 2'd1, 4'b0011, 32'h1234_5678, 0, 0, 3, 0, 0, 2'b00, 32'h0, 0);
    // Same-cycle AW/W, late B
    issue(1, 32'h2000_0020, 2'd2, 4'b1111, 32'hCAFE_F00D, 0, 0, 0, 0, 5, 2'b00, 32'h0, 0);
    // SLVERR read, then OKAY read
    issue(0, 32'h3000_0000, 2'd2, 4'h0, 32'h0, 1, 2, 0, 0, 0, 2'b10, 32'hBAD0_0001, 0);
    issue(0, 32'h3000_0004, 2'd0, 4'h0, 32'h0, 0, 0, 0, 0, 0, 2'b00, 32'h0600_D001, 0);
    // Strobe held across m_ready with a new address
    issue(0, 32'h4000_0000, 2'd2, 4'h0, 32'h0, 0, 0, 0, 0, 0, 2'b00, 32'h1111_1111, 0);
    issue(0, 32'h4000_0100, 2'd2, 4'h0, 32'h0, 0, 0, 0, 0, 0, 2'b00, 32'h2222_2222, 1);
    // Zero strobe write forwarded unchanged, issued back-to-back
    issue(1, 32'h4000_0200, 2'd0, 4'b0000, 32'hAAAA_5555, 0, 0, 1, 2, 0, 2'b11, 32'h0, 1);

    // Reset while AR waits for arready
    repeat (2) @(negedge clk);
    d_ar = 1000;
    m_rw = 1'b0; m_a = 32'h5000_0000; m_size = 2'd2; m_strobe = 1'b1;
    @(negedge clk);
    scramble();
    repeat (3) @(negedge clk);
    chk("abort_arvalid_wait", arvalid, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_ar_q.delete(); exp_aw_q.delete(); exp_w_q.delete(); exp_done_q.delete();
    last_rdata = 32'h0;
    chk("abort_arvalid", arvalid, 0);
    chk("abort_m_ready", m_ready, 0);
    chk("abort_m_dout", m_dout, 0);
    issue(1, 32'h5000_0040, 2'd2, 4'b1010, 32'h0BAD_CAFE, 0, 0, 0, 0, 0, 2'b00, 32'h0, 0);
    issue(0, 32'h5000_0044, 2'd2, 4'h0, 32'h0, 0, 0, 0, 0, 0, 2'b00, 32'h7777_0000, 0);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      bit          rw;
      logic [1:0]  resp;
      rw   = 1'($urandom);
      resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(2, 3)) : 2'b00;
      issue(rw, $urandom, 2'($urandom_range(0, 2)), 4'($urandom), $urandom,
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 3), resp, $urandom,
            ($urandom_range(0, 3) == 0));
    end

    repeat (5) @(negedge clk);
    chk("drain_done", exp_done_q.size(), 0);
    chk("drain_ar", exp_ar_q.size(), 0);
    chk("drain_w", exp_w_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
